upc_loop_status_monitor: RTL and testbench
==========================================

# upc_loop_status_monitor

Synthesizable, passive observer of one HLS-generated block: a non-dataflow module handshake (ap_start/ap_ready/ap_done/ap_continue) plus its pipelined-loop FSM (state, stage block, pipeline enables). It produces saturating event and cycle counters for module invocations, loop invocations, iteration starts and ends, and stall cycles. It sits beside each monitored sub-instance in the simulation top and never drives the DUT. All counting freezes once the end-of-test `finish` is seen.

## Interface
- `STATE_W`, 1, width of the FSM state vectors.
- `CNT_W`, 32, width of every counter.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `finish` in 1: end of test; sampled high means freeze.
- `ap_start`, `ap_ready`, `ap_done`, `ap_continue` in 1 each: module handshake.
- `cur_state`, `iter_start_state`, `iter_end_state`, `quit_state` in STATE_W each.
- `iter_start_block`, `iter_end_block`, `quit_block` in 1 each: stage subdone-block, active high.
- `iter_start_enable`, `iter_end_enable`, `quit_enable` in 1 each: first and last pipeline enable regs.
- `loop_start`, `loop_ready`, `loop_done`, `loop_continue`, `quit_at_end` in 1 each.
- `mod_busy` out 1; `mod_start_cnt`, `mod_done_cnt`, `mod_busy_cycles` out CNT_W each.
- `loop_active` out 1; `loop_inv_cnt`, `iter_start_cnt`, `iter_end_cnt`, `stall_cycles` out CNT_W each.
- `inflight` out CNT_W; `frozen` out 1; `underflow_err` out 1 (sticky).

## Operation
- Events (combinational, current cycle):
  - `mod_start_ev` = ap_start & !mod_busy.
  - `mod_done_ev` = ap_done & ap_continue.
  - `loop_start_ev` = loop_start & !loop_active.
  - `loop_done_ev` = loop_done & loop_continue.
  - `it_start_ev` = (cur_state==iter_start_state) & iter_start_enable & !iter_start_block.
  - `it_end_ev` = (cur_state==iter_end_state) & iter_end_enable & !iter_end_block.
  - `quit_ev` = (cur_state==quit_state) & quit_enable & !quit_block & quit_at_end.
  - `stall_ev` = loop_active & (cur_state==iter_start_state) & iter_start_block.
- `mod_busy` next value = (mod_busy | mod_start_ev) & !mod_done_ev. Exception: a start and a done in the same cycle while busy (back-to-back invocation) keep `mod_busy` at 1.
- `loop_active` follows the same rule using loop_start_ev/loop_done_ev.
- Each `*_ev` increments its counter by 1. `quit_ev` increments `iter_end_cnt` only if it_end_ev is not also asserted; it is never double counted.
- `mod_busy_cycles` increments on every cycle the registered `mod_busy` is 1.
- `inflight` is +1 on it_start_ev and -1 on an iteration end.
  - Both in the same cycle: unchanged.
  - A decrement at 0: value stays 0 and `underflow_err` is set.
- `ap_ready` and `loop_ready` are informational only; they do not affect any counter.
- Freeze: the first cycle `finish`=1 sets `frozen`. From that edge on, no register changes until reset. Events in the cycle finish is first high are still counted.
- All counters saturate at 2^CNT_W-1; an increment at maximum holds the value.

## Timing
- An event in cycle N is visible on the outputs after edge N+1. Outputs are registered with no combinational path from inputs.
- Reset (synchronous, any time, including mid-loop or while frozen) clears all outputs to 0 at the next edge. No events are counted in the reset cycle.
- After reset deasserts, counting starts in the first cycle with reset=0.

## Structure
- Shared package `upc_mon_pkg`: default CNT_W, a saturating-increment function, and an enum of event indices for the log encoding.
- One sub-module, `sat_counter` (CNT_W parameter, inc, dec, clr, hold), instantiated per counter. `inflight` uses its dec input.
- The top contains only the event decode and the two busy/active flags.

## Test plan
- Reset, then a single invocation: ap_start high for 1 cycle, ap_done&ap_continue at cycle 10 → mod_start_cnt=1, mod_done_cnt=1, mod_busy_cycles=9, mod_busy=0.
- Loop with II=1 and depth 3: 8 iterations with no blocks → iter_start_cnt=8, iter_end_cnt=8, inflight peaks at 3 and returns to 0, loop_inv_cnt=1.
- Hold iter_start_block high for 4 cycles inside state iter_start_state while loop_active → stall_cycles=4, with no iteration counted in those cycles.
- Same-cycle start and done on a busy module → counts 2/1 → 2/2 progression, mod_busy stays 1. Same-cycle it_start_ev and it_end_ev → inflight unchanged.
- it_end_ev with inflight=0 → underflow_err=1, inflight=0. Then assert finish with events continuing → frozen=1, counters hold; reset → all 0.
- With CNT_W=4, 20 iteration starts → iter_start_cnt=15 (saturated).

Source files
------------

// File: rtl/upc_mon_pkg.sv
// Shared definitions for the HLS loop/status monitor: default counter width,
// saturating step helper and event indices used for the event vector.
package upc_mon_pkg;

  localparam int unsigned DefaultCntW = 32;
  localparam int unsigned NumEv       = 8;

  typedef enum logic [2:0] {
    EvModStart  = 3'd0,
    EvModDone   = 3'd1,
    EvLoopStart = 3'd2,
    EvLoopDone  = 3'd3,
    EvItStart   = 3'd4,
    EvItEnd     = 3'd5,
    EvQuit      = 3'd6,
    EvStall     = 3'd7
  } upc_ev_e;

  // Up/down step clamped to [0, max_val]; simultaneous up and down cancel.
  function automatic logic [63:0] sat_step(input logic [63:0] val,
                                           input logic [63:0] max_val,
                                           input logic        up,
                                           input logic        down);
    logic [63:0] res;
    res = val;
    if (up && !down && (val != max_val)) begin
      res = val + 64'd1;
    end else if (down && !up && (val != 64'd0)) begin
      res = val - 64'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up/down counter with synchronous clear and a freeze (hold) input.
module sat_counter
  import upc_mon_pkg::*;
#(
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             hold_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] MaxVal = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!hold_i) begin
      cnt_d = CNT_W'(sat_step(64'(cnt_q), 64'(MaxVal), inc_i, dec_i));
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/upc_loop_status_monitor.sv
// Passive observer of an HLS module handshake and its pipelined-loop FSM;
// decodes events and feeds saturating counters, freezing on finish.
module upc_loop_status_monitor
  import upc_mon_pkg::*;
#(
  parameter int unsigned STATE_W = 1,
  parameter int unsigned CNT_W   = DefaultCntW
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               finish,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  output logic               mod_busy,
  output logic [CNT_W-1:0]   mod_start_cnt,
  output logic [CNT_W-1:0]   mod_done_cnt,
  output logic [CNT_W-1:0]   mod_busy_cycles,
  output logic               loop_active,
  output logic [CNT_W-1:0]   loop_inv_cnt,
  output logic [CNT_W-1:0]   iter_start_cnt,
  output logic [CNT_W-1:0]   iter_end_cnt,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   inflight,
  output logic               frozen,
  output logic               underflow_err
);

  logic mod_busy_q, mod_busy_d;
  logic loop_active_q, loop_active_d;
  logic frozen_q, underflow_q;
  logic mod_start_ev, mod_done_ev, loop_start_ev, loop_done_ev;
  logic it_start_ev, it_end_ev, quit_ev, stall_ev;
  logic iter_end_any, underflow_set;
  logic [NumEv-1:0] ev;

  // Ready strobes are informational only.
  logic unused_ready;
  assign unused_ready = ap_ready | loop_ready;

  always_comb begin
    mod_done_ev   = ap_done & ap_continue;
    mod_start_ev  = ap_start & ~mod_busy_q;
    loop_done_ev  = loop_done & loop_continue;
    loop_start_ev = loop_start & ~loop_active_q;
    it_start_ev   = (cur_state == iter_start_state) & iter_start_enable & ~iter_start_block;
    it_end_ev     = (cur_state == iter_end_state) & iter_end_enable & ~iter_end_block;
    quit_ev       = (cur_state == quit_state) & quit_enable & ~quit_block & quit_at_end;
    stall_ev      = loop_active_q & (cur_state == iter_start_state) & iter_start_block;

    ev              = '0;
    ev[EvModStart]  = mod_start_ev;
    ev[EvModDone]   = mod_done_ev;
    ev[EvLoopStart] = loop_start_ev;
    ev[EvLoopDone]  = loop_done_ev;
    ev[EvItStart]   = it_start_ev;
    ev[EvItEnd]     = it_end_ev;
    ev[EvQuit]      = quit_ev;
    ev[EvStall]     = stall_ev;

    // A quit that coincides with a normal end is one iteration end, not two.
    iter_end_any  = ev[EvItEnd] | ev[EvQuit];
    underflow_set = iter_end_any & ~ev[EvItStart] & (inflight == '0);

    // Back-to-back (raw start with done while busy) keeps the flag set.
    if (mod_busy_q) begin
      mod_busy_d = ~mod_done_ev | ap_start;
    end else begin
      mod_busy_d = mod_start_ev & ~mod_done_ev;
    end
    if (loop_active_q) begin
      loop_active_d = ~loop_done_ev | loop_start;
    end else begin
      loop_active_d = loop_start_ev & ~loop_done_ev;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mod_busy_q    <= 1'b0;
      loop_active_q <= 1'b0;
      frozen_q      <= 1'b0;
      underflow_q   <= 1'b0;
    end else if (!frozen_q) begin
      mod_busy_q    <= mod_busy_d;
      loop_active_q <= loop_active_d;
      frozen_q      <= finish;
      underflow_q   <= underflow_q | underflow_set;
    end
  end

  assign mod_busy      = mod_busy_q;
  assign loop_active   = loop_active_q;
  assign frozen        = frozen_q;
  assign underflow_err = underflow_q;

  sat_counter #(.CNT_W(CNT_W)) u_mod_start (
    .clk_i(clock), .clr_i(reset), .hold_i(frozen_q),
    .inc_i(ev[EvModStart]), .dec_i(1'b0), .cnt_o(mod_start_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mod_done (
    .clk_i(clock), .clr_i(reset), .hold_i(frozen_q),
    .inc_i(ev[EvModDone]), .dec_i(1'b0), .cnt_o(mod_done_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mod_busy_cycles (
    .clk_i(clock), .clr_i(reset), .hold_i(frozen_q),
    .inc_i(mod_busy_q), .dec_i(1'b0), .cnt_o(mod_busy_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_loop_inv (
    .clk_i(clock), .clr_i(reset), .hold_i(frozen_q),
    .inc_i(ev[EvLoopStart]), .dec_i(1'b0), .cnt_o(loop_inv_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_iter_start (
    .clk_i(clock), .clr_i(reset), .hold_i(frozen_q),
    .inc_i(ev[EvItStart]), .dec_i(1'b0), .cnt_o(iter_start_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_iter_end (
    .clk_i(clock), .clr_i(reset), .hold_i(frozen_q),
    .inc_i(iter_end_any), .dec_i(1'b0), .cnt_o(iter_end_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk_i(clock), .clr_i(reset), .hold_i(frozen_q),
    .inc_i(ev[EvStall]), .dec_i(1'b0), .cnt_o(stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_inflight (
    .clk_i(clock), .clr_i(reset), .hold_i(frozen_q),
    .inc_i(ev[EvItStart]), .dec_i(iter_end_any), .cnt_o(inflight)
  );

endmodule

// File: tb/tb_upc_loop_status_monitor.sv
// Bench: directed scenarios plus random stimulus against a cycle-level model,
// driving a 32-bit and a 4-bit counter instance from the same inputs.
module tb_upc_loop_status_monitor;

  localparam longint Max32 = 64'hFFFF_FFFF;
  localparam longint Max4  = 15;

  logic clock = 1'b0;
  logic reset, finish;
  logic ap_start, ap_ready, ap_done, ap_continue;
  logic [1:0] cur_state, iter_start_state, iter_end_state, quit_state;
  logic iter_start_block, iter_end_block, quit_block;
  logic iter_start_enable, iter_end_enable, quit_enable;
  logic loop_start, loop_ready, loop_done, loop_continue, quit_at_end;

  logic        b_mod_busy, b_loop_active, b_frozen, b_uf;
  logic [31:0] b_ms, b_md, b_bc, b_li, b_is, b_ie, b_st, b_inf;
  logic        s_mod_busy, s_loop_active, s_frozen, s_uf;
  logic [3:0]  s_ms, s_md, s_bc, s_li, s_is, s_ie, s_st, s_inf;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: flags and unbounded event totals.
  bit     m_busy, m_act, m_frozen, m_uf, m_uf4;
  longint c_ms, c_md, c_bc, c_li, c_is, c_ie, c_st, m_inf, m_inf4;
  longint peak;

  always #5 clock = ~clock;

  upc_loop_status_monitor #(.STATE_W(2), .CNT_W(32)) u_dut_big (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
    .quit_block(quit_block), .iter_start_enable(iter_start_enable),
    .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .mod_busy(b_mod_busy), .mod_start_cnt(b_ms), .mod_done_cnt(b_md),
    .mod_busy_cycles(b_bc), .loop_active(b_loop_active), .loop_inv_cnt(b_li),
    .iter_start_cnt(b_is), .iter_end_cnt(b_ie), .stall_cycles(b_st),
    .inflight(b_inf), .frozen(b_frozen), .underflow_err(b_uf)
  );

  upc_loop_status_monitor #(.STATE_W(2), .CNT_W(4)) u_dut_small (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
    .quit_block(quit_block), .iter_start_enable(iter_start_enable),
    .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .mod_busy(s_mod_busy), .mod_start_cnt(s_ms), .mod_done_cnt(s_md),
    .mod_busy_cycles(s_bc), .loop_active(s_loop_active), .loop_inv_cnt(s_li),
    .iter_start_cnt(s_is), .iter_end_cnt(s_ie), .stall_cycles(s_st),
    .inflight(s_inf), .frozen(s_frozen), .underflow_err(s_uf)
  );

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint capped(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic longint infl_next(input longint v, input bit up, input bit down,
                                       input longint maxv);
    if (up && !down) return (v >= maxv) ? maxv : v + 1;
    if (down && !up) return (v == 0) ? 0 : v - 1;
    return v;
  endfunction

  task automatic compare_all();
    check_eq("mod_busy", longint'(b_mod_busy), longint'(m_busy));
    check_eq("mod_start_cnt", longint'(b_ms), capped(c_ms, Max32));
    check_eq("mod_done_cnt", longint'(b_md), capped(c_md, Max32));
    check_eq("mod_busy_cycles", longint'(b_bc), capped(c_bc, Max32));
    check_eq("loop_active", longint'(b_loop_active), longint'(m_act));
    check_eq("loop_inv_cnt", longint'(b_li), capped(c_li, Max32));
    check_eq("iter_start_cnt", longint'(b_is), capped(c_is, Max32));
    check_eq("iter_end_cnt", longint'(b_ie), capped(c_ie, Max32));
    check_eq("stall_cycles", longint'(b_st), capped(c_st, Max32));
    check_eq("inflight", longint'(b_inf), m_inf);
    check_eq("frozen", longint'(b_frozen), longint'(m_frozen));
    check_eq("underflow_err", longint'(b_uf), longint'(m_uf));
    check_eq("w4_mod_busy_cycles", longint'(s_bc), capped(c_bc, Max4));
    check_eq("w4_iter_start_cnt", longint'(s_is), capped(c_is, Max4));
    check_eq("w4_iter_end_cnt", longint'(s_ie), capped(c_ie, Max4));
    check_eq("w4_stall_cycles", longint'(s_st), capped(c_st, Max4));
    check_eq("w4_inflight", longint'(s_inf), m_inf4);
    check_eq("w4_underflow_err", longint'(s_uf), longint'(m_uf4));
  endtask

  // One clock: classify this cycle's inputs, advance the model at the edge, compare.
  task automatic cyc();
    bit ms, md, ls, ld, is, ie, q, st, any_end;
    md = ap_done && ap_continue;
    ms = ap_start && !m_busy;
    ld = loop_done && loop_continue;
    ls = loop_start && !m_act;
    is = (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
    ie = (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
    q  = (cur_state == quit_state) && quit_enable && !quit_block && quit_at_end;
    st = m_act && (cur_state == iter_start_state) && iter_start_block;
    any_end = ie || q;
    @(posedge clock);
    if (reset) begin
      {m_busy, m_act, m_frozen, m_uf, m_uf4} = '0;
      {c_ms, c_md, c_bc, c_li, c_is, c_ie, c_st, m_inf, m_inf4} = '0;
    end else if (!m_frozen) begin
      c_ms += ms; c_md += md; c_li += ls; c_is += is; c_ie += any_end; c_st += st;
      if (m_busy) c_bc++;
      if (any_end && !is && m_inf == 0)  m_uf  = 1'b1;
      if (any_end && !is && m_inf4 == 0) m_uf4 = 1'b1;
      m_inf  = infl_next(m_inf, is, any_end, Max32);
      m_inf4 = infl_next(m_inf4, is, any_end, Max4);
      // Busy: raw start alongside done while busy re-arms; otherwise done wins.
      if (m_busy) m_busy = !md || ap_start;
      else        m_busy = ms && !md;
      if (m_act) m_act = !ld || loop_start;
      else       m_act = ls && !ld;
      m_frozen = finish;
    end
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    finish = 0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0;
    cur_state = 0; iter_start_state = 1; iter_end_state = 2; quit_state = 3;
    iter_start_block = 0; iter_end_block = 0; quit_block = 0;
    iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
    loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0; quit_at_end = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    cyc();
    reset = 0;
  endtask

  initial begin
    do_reset();
    check_eq("reset_mod_start_cnt", longint'(b_ms), 0);
    check_eq("reset_inflight", longint'(b_inf), 0);

    // Single invocation: start in cycle 1, done in cycle 10.
    ap_start = 1; cyc(); ap_start = 0;
    repeat (8) cyc();
    ap_done = 1; ap_continue = 1; cyc(); ap_done = 0; ap_continue = 0;
    check_eq("inv_start", longint'(b_ms), 1);
    check_eq("inv_done", longint'(b_md), 1);
    check_eq("inv_busy_cycles", longint'(b_bc), 9);
    check_eq("inv_busy", longint'(b_mod_busy), 0);

    // Pipelined loop: 8 iterations, each ending three cycles after it starts.
    do_reset();
    cur_state = 1; iter_start_state = 1; iter_end_state = 1;
    loop_start = 1; cyc(); loop_start = 0;
    peak = 0;
    for (int k = 0; k < 11; k++) begin
      iter_start_enable = (k < 8);
      iter_end_enable   = (k >= 3);
      cyc();
      if (longint'(b_inf) > peak) peak = longint'(b_inf);
    end
    iter_start_enable = 0; iter_end_enable = 0;
    loop_done = 1; loop_continue = 1; cyc(); loop_done = 0; loop_continue = 0;
    check_eq("loop_iter_start", longint'(b_is), 8);
    check_eq("loop_iter_end", longint'(b_ie), 8);
    check_eq("loop_inflight_peak", peak, 3);
    check_eq("loop_inflight_end", longint'(b_inf), 0);
    check_eq("loop_inv", longint'(b_li), 1);
    check_eq("loop_active_end", longint'(b_loop_active), 0);

    // Stall: start stage blocked for four cycles while the loop is active.
    do_reset();
    cur_state = 1; iter_start_state = 1;
    loop_start = 1; cyc(); loop_start = 0;
    iter_start_enable = 1; iter_start_block = 1;
    repeat (4) cyc();
    check_eq("stall_cycles", longint'(b_st), 4);
    check_eq("stall_no_iter", longint'(b_is), 0);
    iter_start_block = 0; cyc(); iter_start_enable = 0;
    check_eq("stall_release_iter", longint'(b_is), 1);

    // Back-to-back module invocation.
    do_reset();
    ap_start = 1; cyc(); ap_start = 0;
    ap_done = 1; ap_continue = 1; cyc();
    ap_done = 0; ap_start = 1; cyc();
    check_eq("b2b_start_a", longint'(b_ms), 2);
    check_eq("b2b_done_a", longint'(b_md), 1);
    ap_done = 1; cyc(); ap_start = 0; ap_done = 0; ap_continue = 0;
    check_eq("b2b_start_b", longint'(b_ms), 2);
    check_eq("b2b_done_b", longint'(b_md), 2);
    check_eq("b2b_busy", longint'(b_mod_busy), 1);

    // Underflow, then freeze with events still arriving, then reset.
    do_reset();
    cur_state = 2; iter_end_enable = 1; cyc(); iter_end_enable = 0;
    check_eq("uf_flag", longint'(b_uf), 1);
    check_eq("uf_inflight", longint'(b_inf), 0);
    finish = 1; ap_start = 1; cyc();
    check_eq("frz_flag", longint'(b_frozen), 1);
    check_eq("frz_last_start", longint'(b_ms), 1);
    finish = 0; ap_done = 1; ap_continue = 1;
    cur_state = 1; iter_start_enable = 1;
    repeat (3) cyc();
    check_eq("frz_hold_done", longint'(b_md), 0);
    check_eq("frz_hold_iter", longint'(b_is), 0);
    do_reset();
    check_eq("post_frz_frozen", longint'(b_frozen), 0);
    check_eq("post_frz_uf", longint'(b_uf), 0);
    check_eq("post_frz_start", longint'(b_ms), 0);

    // Saturation: 20 iteration starts into the 4-bit instance.
    cur_state = 1; iter_start_enable = 1;
    repeat (20) cyc();
    iter_start_enable = 0;
    check_eq("sat_w4_iter_start", longint'(s_is), 15);
    check_eq("sat_w32_iter_start", longint'(b_is), 20);

    // Random traffic with occasional reset and finish.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(63) == 0);
      finish = ($urandom_range(127) == 0);
      {ap_start, ap_ready, ap_done, ap_continue} = 4'($urandom);
      {loop_start, loop_ready, loop_done, loop_continue, quit_at_end} = 5'($urandom);
      {iter_start_block, iter_end_block, quit_block} = 3'($urandom);
      {iter_start_enable, iter_end_enable, quit_enable} = 3'($urandom);
      cur_state = 2'($urandom); iter_start_state = 2'($urandom);
      iter_end_state = 2'($urandom); quit_state = 2'($urandom);
      cyc();
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
